// File: rtl/avalon_st_pkt_arbiter.sv
// Packet-granular round-robin arbiter: forwards whole SOP..EOP packets from one
// granted Avalon-ST sink at a time through a single registered source stage.
module avalon_st_pkt_arbiter #(
  parameter int DWIDTH        = 64,
  parameter int EMPTY_WIDTH   = $clog2(DWIDTH/8),
  parameter int N_PORTS       = 4,
  parameter int CHANNEL_WIDTH = $clog2(N_PORTS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_PORTS*DWIDTH-1:0]        snk_data_i,
  input  logic [N_PORTS-1:0]               snk_valid_i,
  input  logic [N_PORTS-1:0]               snk_startofpacket_i,
  input  logic [N_PORTS-1:0]               snk_endofpacket_i,
  input  logic [N_PORTS*EMPTY_WIDTH-1:0]   snk_empty_i,
  output logic [N_PORTS-1:0]               snk_ready_o,
  output logic [DWIDTH-1:0]                src_data_o,
  output logic                             src_valid_o,
  output logic                             src_startofpacket_o,
  output logic                             src_endofpacket_o,
  output logic [EMPTY_WIDTH-1:0]           src_empty_o,
  output logic [CHANNEL_WIDTH-1:0]         src_channel_o,
  input  logic                             src_ready_i,
  output logic                             orphan_o
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                   state_r;
  logic [CHANNEL_WIDTH-1:0] gnt_r;
  logic [CHANNEL_WIDTH-1:0] last_r;
  logic [CHANNEL_WIDTH-1:0] next_gnt_s;
  logic [N_PORTS-1:0]       req_s;
  logic [N_PORTS-1:0]       orphan_s;
  logic [N_PORTS-1:0]       gnt_oh_s;
  logic [N_PORTS-1:0]       ready_s;
  logic                     adv_s;
  logic [DWIDTH-1:0]        sel_data_s;
  logic [EMPTY_WIDTH-1:0]   sel_empty_s;
  logic                     sel_valid_s;
  logic                     sel_sop_s;
  logic                     sel_eop_s;

  logic [DWIDTH-1:0]        src_data_r;
  logic                     src_valid_r;
  logic                     src_sop_r;
  logic                     src_eop_r;
  logic [EMPTY_WIDTH-1:0]   src_empty_r;
  logic [CHANNEL_WIDTH-1:0] src_channel_r;
  logic                     orphan_r;

  // Nearest requester after last_ptr wins: scanning farthest-first lets the closest overwrite.
  function automatic logic [CHANNEL_WIDTH-1:0] rr_pick(
    input logic [N_PORTS-1:0]       req,
    input logic [CHANNEL_WIDTH-1:0] last_ptr
  );
    logic [CHANNEL_WIDTH-1:0] pick;
    int                       idx;
    pick = last_ptr;
    for (int i = N_PORTS; i >= 1; i--) begin
      idx = (int'(last_ptr) + i) % N_PORTS;
      if (req[idx[CHANNEL_WIDTH-1:0]]) pick = idx[CHANNEL_WIDTH-1:0];
      else                             pick = pick;
    end
    return pick;
  endfunction

  // Per-port request/orphan classification and the round-robin choice.
  always_comb begin
    req_s      = snk_valid_i & snk_startofpacket_i;
    orphan_s   = snk_valid_i & ~snk_startofpacket_i;
    next_gnt_s = rr_pick(req_s, last_r);
    adv_s      = !src_valid_r || src_ready_i;
    gnt_oh_s   = '0;
    gnt_oh_s[gnt_r] = 1'b1;
  end

  // Mux of the granted port's beat.
  always_comb begin
    sel_data_s  = '0;
    sel_empty_s = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      sel_data_s  = sel_data_s  | (snk_data_i[k*DWIDTH +: DWIDTH] & {DWIDTH{gnt_oh_s[k]}});
      sel_empty_s = sel_empty_s | (snk_empty_i[k*EMPTY_WIDTH +: EMPTY_WIDTH] & {EMPTY_WIDTH{gnt_oh_s[k]}});
    end
    sel_valid_s = |(snk_valid_i & gnt_oh_s);
    sel_sop_s   = |(snk_startofpacket_i & gnt_oh_s);
    sel_eop_s   = |(snk_endofpacket_i & gnt_oh_s);
  end

  // Ready steering: granted port follows adv; in IDLE only orphan beats are drained.
  always_comb begin
    ready_s = '0;
    if (!rst_n) begin
      ready_s = '0;
    end else begin
      case (state_r)
        BUSY:    ready_s = adv_s ? gnt_oh_s : '0;
        IDLE:    ready_s = orphan_s;
        default: ready_s = '0;
      endcase
    end
  end

  // Arbitration FSM and registered source stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      gnt_r         <= '0;
      last_r        <= CHANNEL_WIDTH'(N_PORTS - 1);
      src_data_r    <= '0;
      src_valid_r   <= 1'b0;
      src_sop_r     <= 1'b0;
      src_eop_r     <= 1'b0;
      src_empty_r   <= '0;
      src_channel_r <= '0;
      orphan_r      <= 1'b0;
    end else begin
      orphan_r <= (state_r == IDLE) && (|orphan_s);
      case (state_r)
        IDLE: begin
          if (src_ready_i) src_valid_r <= 1'b0;
          if (|req_s) begin
            gnt_r   <= next_gnt_s;
            last_r  <= next_gnt_s;
            state_r <= BUSY;
          end
        end
        BUSY: begin
          if (adv_s) begin
            if (sel_valid_s) begin
              src_data_r    <= sel_data_s;
              src_valid_r   <= 1'b1;
              src_sop_r     <= sel_sop_s;
              src_eop_r     <= sel_eop_s;
              src_empty_r   <= sel_empty_s;
              src_channel_r <= gnt_r;
              if (sel_eop_s) state_r <= IDLE;
            end else begin
              src_valid_r <= 1'b0;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign snk_ready_o         = ready_s;
  assign src_data_o          = src_data_r;
  assign src_valid_o         = src_valid_r;
  assign src_startofpacket_o = src_sop_r;
  assign src_endofpacket_o   = src_eop_r;
  assign src_empty_o         = src_empty_r;
  assign src_channel_o       = src_channel_r;
  assign orphan_o            = orphan_r;

endmodule

// File: tb/tb_avalon_st_pkt_arbiter.sv
// Self-checking bench for avalon_st_pkt_arbiter: directed scenarios plus random
// traffic checked against per-port packet queues.
module tb_avalon_st_pkt_arbiter;
  localparam int DW = 64;
  localparam int EW = 3;
  localparam int NP = 4;
  localparam int CW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NP*DW-1:0] snk_data_i;
  logic [NP-1:0]    snk_valid_i;
  logic [NP-1:0]    snk_startofpacket_i;
  logic [NP-1:0]    snk_endofpacket_i;
  logic [NP*EW-1:0] snk_empty_i;
  logic [NP-1:0]    snk_ready_o;
  logic [DW-1:0]    src_data_o;
  logic             src_valid_o;
  logic             src_startofpacket_o;
  logic             src_endofpacket_o;
  logic [EW-1:0]    src_empty_o;
  logic [CW-1:0]    src_channel_o;
  logic             src_ready_i;
  logic             orphan_o;

  avalon_st_pkt_arbiter #(.DWIDTH(DW), .N_PORTS(NP)) dut (
    .clk(clk), .rst_n(rst_n),
    .snk_data_i(snk_data_i), .snk_valid_i(snk_valid_i),
    .snk_startofpacket_i(snk_startofpacket_i), .snk_endofpacket_i(snk_endofpacket_i),
    .snk_empty_i(snk_empty_i), .snk_ready_o(snk_ready_o),
    .src_data_o(src_data_o), .src_valid_o(src_valid_o),
    .src_startofpacket_o(src_startofpacket_o), .src_endofpacket_o(src_endofpacket_o),
    .src_empty_o(src_empty_o), .src_channel_o(src_channel_o),
    .src_ready_i(src_ready_i), .orphan_o(orphan_o)
  );

  always #5 clk = ~clk;

  beat_t         txq[NP][$];
  beat_t         expq[NP][$];
  beat_t         obs_beat[$];
  logic [CW-1:0] obs_ch[$];
  int            obs_cyc[$];
  int            cyc = 0;
  int            pass_cnt = 0;
  int            total_cnt = 0;

  logic [NP-1:0] cur_ready;
  logic          cur_sv;
  beat_t         cur_beat;
  logic [CW-1:0] cur_ch;
  logic          cur_orphan;

  task automatic zero_inputs();
    snk_data_i = '0; snk_valid_i = '0; snk_startofpacket_i = '0;
    snk_endofpacket_i = '0; snk_empty_i = '0;
  endtask

  task automatic clear_all();
    for (int k = 0; k < NP; k++) begin
      txq[k].delete();
      expq[k].delete();
    end
    obs_beat.delete(); obs_ch.delete(); obs_cyc.delete();
  endtask

  task automatic push_beat(input int port, input logic [DW-1:0] d, input logic s,
                           input logic e, input logic [EW-1:0] em);
    beat_t b;
    b.data = d; b.sop = s; b.eop = e; b.empty = em;
    txq[port].push_back(b);
  endtask

  // One clock: drive heads of enabled port queues, sample outputs off-edge, log handshakes.
  task automatic step(input logic srdy, input logic [NP-1:0] en);
    beat_t b;
    @(negedge clk);
    for (int k = 0; k < NP; k++) begin
      if (en[k] && txq[k].size() > 0) begin
        b = txq[k][0];
        snk_data_i[k*DW +: DW]  = b.data;
        snk_valid_i[k]          = 1'b1;
        snk_startofpacket_i[k]  = b.sop;
        snk_endofpacket_i[k]    = b.eop;
        snk_empty_i[k*EW +: EW] = b.empty;
      end else begin
        snk_data_i[k*DW +: DW]  = '0;
        snk_valid_i[k]          = 1'b0;
        snk_startofpacket_i[k]  = 1'b0;
        snk_endofpacket_i[k]    = 1'b0;
        snk_empty_i[k*EW +: EW] = '0;
      end
    end
    src_ready_i = srdy;
    #1;
    cur_ready      = snk_ready_o;
    cur_sv         = src_valid_o;
    cur_beat.data  = src_data_o;
    cur_beat.sop   = src_startofpacket_o;
    cur_beat.eop   = src_endofpacket_o;
    cur_beat.empty = src_empty_o;
    cur_ch         = src_channel_o;
    cur_orphan     = orphan_o;
    if (src_valid_o && srdy) begin
      obs_beat.push_back(cur_beat);
      obs_ch.push_back(src_channel_o);
      obs_cyc.push_back(cyc);
    end
    for (int k = 0; k < NP; k++) begin
      if (snk_valid_i[k] && snk_ready_o[k]) b = txq[k].pop_front();
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    zero_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_obs(input int n, input int budget, input string name);
    int t;
    t = 0;
    while (obs_beat.size() < n && t < budget) begin
      step(1'b1, 4'hF);
      t++;
    end
    if (obs_beat.size() < n) begin
      total_cnt++;
      $display("FAIL %s_timeout: got %0d beats, wanted %0d", name, obs_beat.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; src_ready_i = 1'b0; zero_inputs();
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (src_valid_o !== 1'b0) $display("FAIL rst_valid: got %b want 0", src_valid_o); else pass_cnt++;
    total_cnt++;
    if (src_data_o !== '0) $display("FAIL rst_data: got %h want 0", src_data_o); else pass_cnt++;
    total_cnt++;
    if ({src_startofpacket_o, src_endofpacket_o, src_empty_o, src_channel_o} !== 7'd0)
      $display("FAIL rst_ctrl: got %b want 0", {src_startofpacket_o, src_endofpacket_o, src_empty_o, src_channel_o});
    else pass_cnt++;
    total_cnt++;
    if ({snk_ready_o, orphan_o} !== 5'd0) $display("FAIL rst_ready_orphan: got %b want 0", {snk_ready_o, orphan_o});
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_packet();
    beat_t eb;
    logic [DW-1:0] ed [4];
    ed[0] = 64'h11; ed[1] = 64'h22; ed[2] = 64'h33; ed[3] = 64'h44;
    clear_all();
    push_beat(2, ed[0], 1'b1, 1'b0, 3'd0);
    push_beat(2, ed[1], 1'b0, 1'b0, 3'd0);
    push_beat(2, ed[2], 1'b0, 1'b0, 3'd0);
    push_beat(2, ed[3], 1'b0, 1'b1, 3'd3);
    step(1'b1, 4'hF);
    total_cnt++;
    if (cur_ready !== 4'b0000) $display("FAIL sp_ready_idle: got %b want 0000", cur_ready); else pass_cnt++;
    step(1'b1, 4'hF);
    total_cnt++;
    if (cur_ready !== 4'b0100) $display("FAIL sp_ready_grant: got %b want 0100", cur_ready); else pass_cnt++;
    wait_obs(4, 20, "sp");
    for (int i = 0; i < 4; i++) begin
      eb.data = ed[i]; eb.sop = (i == 0); eb.eop = (i == 3); eb.empty = (i == 3) ? 3'd3 : 3'd0;
      total_cnt++;
      if (obs_beat[i] !== eb || obs_ch[i] !== 2'd2)
        $display("FAIL sp_beat%0d: got %h ch %0d want %h ch 2", i, obs_beat[i], obs_ch[i], eb);
      else pass_cnt++;
    end
    total_cnt++;
    if (obs_cyc[3] - obs_cyc[0] !== 3) $display("FAIL sp_contig: got span %0d want 3", obs_cyc[3] - obs_cyc[0]);
    else pass_cnt++;
    step(1'b1, 4'hF);
    total_cnt++;
    if (cur_sv !== 1'b0) $display("FAIL sp_drain: got valid %b want 0", cur_sv); else pass_cnt++;
  endtask

  task automatic test_two_ports();
    logic [DW-1:0] ed [4];
    logic [CW-1:0] ec [4];
    ed[0] = 64'hA0; ed[1] = 64'hA1; ed[2] = 64'hB0; ed[3] = 64'hB1;
    ec[0] = 2'd0; ec[1] = 2'd0; ec[2] = 2'd1; ec[3] = 2'd1;
    do_reset();
    clear_all();
    push_beat(0, ed[0], 1'b1, 1'b0, 3'd0); push_beat(0, ed[1], 1'b0, 1'b1, 3'd0);
    push_beat(1, ed[2], 1'b1, 1'b0, 3'd0); push_beat(1, ed[3], 1'b0, 1'b1, 3'd0);
    wait_obs(4, 30, "tp");
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (obs_beat[i].data !== ed[i] || obs_ch[i] !== ec[i])
        $display("FAIL tp_beat%0d: got %h ch %0d want %h ch %0d", i, obs_beat[i].data, obs_ch[i], ed[i], ec[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (obs_cyc[2] - obs_cyc[1] !== 2) $display("FAIL tp_gap: got %0d want 2", obs_cyc[2] - obs_cyc[1]);
    else pass_cnt++;
    repeat (3) step(1'b1, 4'hF);
  endtask

  task automatic test_round_robin();
    do_reset();
    clear_all();
    for (int j = 0; j < 3; j++)
      for (int p = 0; p < NP; p++) push_beat(p, 64'(p * 16 + j), 1'b1, 1'b1, 3'd0);
    wait_obs(12, 100, "rr");
    for (int i = 0; i < 12; i++) begin
      total_cnt++;
      if (obs_ch[i] !== CW'(i % NP) || obs_beat[i].data !== 64'((i % NP) * 16 + i / NP))
        $display("FAIL rr_beat%0d: got ch %0d data %h want ch %0d", i, obs_ch[i], obs_beat[i].data, i % NP);
      else pass_cnt++;
    end
    repeat (3) step(1'b1, 4'hF);
  endtask

  task automatic test_backpressure();
    logic    pat [7];
    logic    sr, adv, busy, was_stall;
    beat_t   held, eb;
    logic [CW-1:0] held_ch;
    logic [NP-1:0] exp_rdy;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1; pat[5] = 0; pat[6] = 1;
    clear_all();
    push_beat(1, 64'hC0, 1'b1, 1'b0, 3'd0);
    push_beat(1, 64'hC1, 1'b0, 1'b0, 3'd0);
    push_beat(1, 64'hC2, 1'b0, 1'b1, 3'd5);
    busy = 1'b0; was_stall = 1'b0; held = '0; held_ch = '0;
    for (int s = 0; s < 14; s++) begin
      sr = (s < 7) ? pat[s] : 1'b1;
      step(sr, 4'b0010);
      adv = !cur_sv || sr;
      exp_rdy = (busy && adv) ? 4'b0010 : 4'b0000;
      total_cnt++;
      if (cur_ready !== exp_rdy) $display("FAIL bp_ready_c%0d: got %b want %b", s, cur_ready, exp_rdy);
      else pass_cnt++;
      if (was_stall) begin
        total_cnt++;
        if (cur_sv !== 1'b1 || cur_beat !== held || cur_ch !== held_ch)
          $display("FAIL bp_hold_c%0d: got %h want %h", s, cur_beat, held);
        else pass_cnt++;
      end
      was_stall = cur_sv && !sr;
      held = cur_beat; held_ch = cur_ch;
      if (!busy && snk_valid_i[1] && snk_startofpacket_i[1]) busy = 1'b1;
      else if (busy && snk_valid_i[1] && snk_ready_o[1] && snk_endofpacket_i[1]) busy = 1'b0;
    end
    total_cnt++;
    if (obs_beat.size() !== 3) $display("FAIL bp_count: got %0d want 3", obs_beat.size()); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      eb.data = 64'hC0 + 64'(i); eb.sop = (i == 0); eb.eop = (i == 2); eb.empty = (i == 2) ? 3'd5 : 3'd0;
      total_cnt++;
      if (obs_beat[i] !== eb || obs_ch[i] !== 2'd1)
        $display("FAIL bp_beat%0d: got %h ch %0d want %h ch 1", i, obs_beat[i], obs_ch[i], eb);
      else pass_cnt++;
    end
  endtask

  task automatic test_orphan();
    logic exp_rdy [4];
    logic exp_orph [4];
    exp_rdy[0] = 1; exp_rdy[1] = 1; exp_rdy[2] = 0; exp_rdy[3] = 0;
    exp_orph[0] = 0; exp_orph[1] = 1; exp_orph[2] = 1; exp_orph[3] = 0;
    clear_all();
    push_beat(3, 64'hD0, 1'b0, 1'b0, 3'd0);
    push_beat(3, 64'hD1, 1'b0, 1'b0, 3'd0);
    for (int s = 0; s < 4; s++) begin
      step(1'b1, 4'hF);
      total_cnt++;
      if (cur_ready[3] !== exp_rdy[s] || cur_orphan !== exp_orph[s] || cur_sv !== 1'b0)
        $display("FAIL orphan_c%0d: got rdy %b orph %b v %b want rdy %b orph %b v 0",
                 s, cur_ready[3], cur_orphan, cur_sv, exp_rdy[s], exp_orph[s]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_packet();
    clear_all();
    for (int i = 0; i < 5; i++) push_beat(1, 64'hE0 + 64'(i), i == 0, i == 4, 3'd0);
    wait_obs(1, 20, "rm");
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({src_valid_o, src_startofpacket_o, src_endofpacket_o, src_empty_o, src_channel_o, orphan_o} !== 9'd0 ||
        src_data_o !== '0 || snk_ready_o !== 4'b0000)
      $display("FAIL rm_outputs: got v %b d %h rdy %b want all 0", src_valid_o, src_data_o, snk_ready_o);
    else pass_cnt++;
    clear_all();
    @(negedge clk);
    zero_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    push_beat(1, 64'hF1, 1'b1, 1'b1, 3'd0);
    push_beat(0, 64'hF0, 1'b1, 1'b1, 3'd0);
    wait_obs(2, 20, "rm");
    repeat (4) step(1'b1, 4'hF);
    total_cnt++;
    if (obs_beat.size() !== 2 || obs_ch[0] !== 2'd0 || obs_beat[0].data !== 64'hF0 ||
        obs_ch[1] !== 2'd1 || obs_beat[1].data !== 64'hF1)
      $display("FAIL rm_regrant: got n %0d ch %0d/%0d want n 2 ch 0/1", obs_beat.size(), obs_ch[0], obs_ch[1]);
    else pass_cnt++;
  endtask

  task automatic test_random();
    beat_t b, eb;
    int total_beats, done, t, len;
    logic in_pkt;
    logic [CW-1:0] pkt_ch;
    do_reset();
    clear_all();
    total_beats = 0;
    for (int p = 0; p < NP; p++) begin
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
        len = $urandom_range(1, 4);
        for (int i = 0; i < len; i++) begin
          b.data = {$urandom, $urandom}; b.sop = (i == 0); b.eop = (i == len - 1);
          b.empty = EW'($urandom);
          txq[p].push_back(b); expq[p].push_back(b);
          total_beats++;
        end
      end
    end
    done = 0; t = 0; in_pkt = 1'b0; pkt_ch = '0;
    while (done < total_beats && t < 3000) begin
      step($urandom_range(0, 3) != 0, NP'($urandom));
      t++;
      while (done < obs_beat.size()) begin
        if (in_pkt) begin
          total_cnt++;
          if (obs_ch[done] !== pkt_ch) $display("FAIL rnd_interleave%0d: got ch %0d want %0d", done, obs_ch[done], pkt_ch);
          else pass_cnt++;
        end
        if (expq[obs_ch[done]].size() > 0) eb = expq[obs_ch[done]].pop_front();
        else eb = '0;
        total_cnt++;
        if (obs_beat[done] !== eb) $display("FAIL rnd_beat%0d: got %h want %h", done, obs_beat[done], eb);
        else pass_cnt++;
        in_pkt = !obs_beat[done].eop;
        pkt_ch = obs_ch[done];
        done++;
      end
    end
    total_cnt++;
    if (done !== total_beats) $display("FAIL rnd_complete: got %0d beats want %0d", done, total_beats);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_two_ports();
    test_round_robin();
    test_backpressure();
    test_orphan();
    test_reset_mid_packet();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
